// File: rtl/shuffle_addr_gen.sv
// Ping-pong address generator in front of the inner-shuffle BRAM: writes tiles
// row-major into one bank while reading the other bank column-major (transpose).
module shuffle_addr_gen #(
   parameter  int WIDTH = 8,
   parameter  int I     = 2,
   parameter  int J     = 3,
   localparam int AW    = $clog2(2 * I * J)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] idat,
   input  logic             ivld,
   output logic             irdy,
   output logic [WIDTH-1:0] wr_data,
   output logic [AW-1:0]    wr_addr,
   output logic             wr_en,
   output logic [AW-1:0]    rd_addr,
   output logic             rd_req_vld,
   input  logic             rd_req_rdy,
   input  logic             rd_ack,
   output logic             busy
);

   localparam int N  = I * J;
   localparam int RW = (I > 1) ? $clog2(I) : 1;
   localparam int CW = (J > 1) ? $clog2(J) : 1;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam int OW = $clog2(2 * N + 1);

   localparam logic [RW-1:0] R_LAST    = RW'(I - 1);
   localparam logic [CW-1:0] C_LAST    = CW'(J - 1);
   localparam logic [KW-1:0] K_LAST    = KW'(N - 1);
   localparam logic [AW-1:0] A_ONE     = AW'(1);
   localparam logic [AW-1:0] A_BASE1   = AW'(N);
   localparam logic [AW-1:0] A_ROWSTEP = AW'(J);
   localparam logic [AW-1:0] A_COLBACK = AW'((I - 1) * J);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FULL   = 2'd1,
      ISSUED = 2'd2
   } bank_st_e;

   bank_st_e          state_q [2];
   bank_st_e          state_d [2];
   logic              wbank_q, wbank_d;
   logic              ibank_q, ibank_d;
   logic              abank_q, abank_d;
   logic [RW-1:0]     wr_r_q, wr_r_d;
   logic [CW-1:0]     wr_c_q, wr_c_d;
   logic [RW-1:0]     rd_r_q, rd_r_d;
   logic [CW-1:0]     rd_c_q, rd_c_d;
   logic [KW-1:0]     ack_q, ack_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic [OW-1:0]     outst_q, outst_d;

   logic wr_fire, rd_fire, wr_last, rd_last, rel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q[0] <= EMPTY;
         state_q[1] <= EMPTY;
         wbank_q    <= 1'b0;
         ibank_q    <= 1'b0;
         abank_q    <= 1'b0;
         wr_r_q     <= '0;
         wr_c_q     <= '0;
         rd_r_q     <= '0;
         rd_c_q     <= '0;
         ack_q      <= '0;
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         outst_q    <= '0;
      end else begin
         state_q    <= state_d;
         wbank_q    <= wbank_d;
         ibank_q    <= ibank_d;
         abank_q    <= abank_d;
         wr_r_q     <= wr_r_d;
         wr_c_q     <= wr_c_d;
         rd_r_q     <= rd_r_d;
         rd_c_q     <= rd_c_d;
         ack_q      <= ack_d;
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         outst_q    <= outst_d;
      end
   end

   always_comb begin
      wr_fire = ivld && (state_q[wbank_q] == EMPTY);
      rd_fire = (state_q[ibank_q] == FULL) && rd_req_rdy;
      wr_last = wr_fire && (wr_r_q == R_LAST) && (wr_c_q == C_LAST);
      rd_last = rd_fire && (rd_r_q == R_LAST) && (rd_c_q == C_LAST);
      rel     = rd_ack && (ack_q == K_LAST);
   end

   always_comb begin
      state_d   = state_q;
      wbank_d   = wbank_q;
      ibank_d   = ibank_q;
      abank_d   = abank_q;
      wr_r_d    = wr_r_q;
      wr_c_d    = wr_c_q;
      rd_r_d    = rd_r_q;
      rd_c_d    = rd_c_q;
      ack_d     = ack_q;
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      outst_d   = outst_q + OW'(rd_fire) - OW'(rd_ack);

      // Row-major writes are contiguous; the tile end jumps to the other bank base.
      if (wr_fire) begin
         if (wr_c_q == C_LAST) begin
            wr_c_d = '0;
            wr_r_d = (wr_r_q == R_LAST) ? '0 : wr_r_q + RW'(1);
         end else begin
            wr_c_d = wr_c_q + CW'(1);
         end
         if (wr_last) begin
            wbank_d    = ~wbank_q;
            wr_addr_d  = wbank_q ? '0 : A_BASE1;
            state_d[wbank_q] = FULL;
         end else begin
            wr_addr_d  = wr_addr_q + A_ONE;
         end
      end

      // Column-major reads: step by J down a column, then back up to the next column.
      if (rd_fire) begin
         if (rd_r_q != R_LAST) begin
            rd_r_d    = rd_r_q + RW'(1);
            rd_addr_d = rd_addr_q + A_ROWSTEP;
         end else if (rd_c_q != C_LAST) begin
            rd_r_d    = '0;
            rd_c_d    = rd_c_q + CW'(1);
            rd_addr_d = rd_addr_q - A_COLBACK + A_ONE;
         end else begin
            rd_r_d    = '0;
            rd_c_d    = '0;
            ibank_d   = ~ibank_q;
            rd_addr_d = ibank_q ? '0 : A_BASE1;
            state_d[ibank_q] = ISSUED;
         end
      end

      if (rd_ack) begin
         if (rel) begin
            ack_d   = '0;
            abank_d = ~abank_q;
            state_d[abank_q] = EMPTY;
         end else begin
            ack_d   = ack_q + KW'(1);
         end
      end
   end

   always_comb begin
      irdy       = (state_q[wbank_q] == EMPTY);
      wr_en      = ivld && irdy;
      wr_data    = idat;
      wr_addr    = wr_addr_q;
      rd_addr    = rd_addr_q;
      rd_req_vld = (state_q[ibank_q] == FULL);
      busy       = (state_q[0] != EMPTY) || (state_q[1] != EMPTY);
   end

   ack_has_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      rd_ack |-> (outst_q != '0));

endmodule
